// File: rtl/correlador_ctrl.sv
// Window correlator controller: accumulates the bipolar XNOR match count over NS
// beats and reports corr = 2*matches - N. The optional peak tracker is enabled by CORR_PEAK_EN.
module correlador_ctrl #(
    parameter  int SAMPLES = 128,
    parameter  int OSF     = 8,
    parameter  int SLICE   = 64,
    localparam int N       = SAMPLES * OSF,
    localparam int NS      = N / SLICE,
    localparam int CW      = $clog2(N) + 2,
    localparam int BW      = $clog2(NS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SLICE-1:0] in_a,
    input  logic [SLICE-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    corr,
    output logic             busy,
    input  logic             peak_clr,
    output logic [CW-1:0]    peak_val,
    output logic [15:0]      peak_idx
);

    // state  | meaning
    // S_IDLE | waiting for start
    // S_RUN  | accepting slice beats
    // S_DONE | result presented until out_ready
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   acc_q, acc_d;
    logic [BW-1:0]   cnt_q, cnt_d;
    logic [15:0]     widx_q, widx_d;
    logic [SLICE-1:0] match;
    logic [CW-1:0]   pc;
    logic            hs;

    assign match = ~(in_a ^ in_b);

    always_comb begin
        pc = '0;
        for (int i = 0; i < SLICE; i++) pc = pc + CW'(match[i]);
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        widx_d  = widx_q;
        case (state_q)
            S_IDLE: if (start) begin
                state_d = S_RUN;
                acc_d   = '0;
                cnt_d   = '0;
            end
            S_RUN: if (in_valid) begin
                acc_d = acc_q + pc;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == BW'(NS - 1)) state_d = S_DONE;
            end
            S_DONE: if (out_ready) begin
                state_d = S_IDLE;
                widx_d  = widx_q + 16'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            widx_q  <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            widx_q  <= widx_d;
        end
    end

    assign in_ready  = (state_q == S_RUN);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_RUN) || (state_q == S_DONE);
    // Modular CW-bit arithmetic: 2*N wraps but the subtraction lands back in range.
    assign corr      = out_valid ? ((acc_q << 1) - CW'(N)) : '0;
    assign hs        = out_valid && out_ready;

`ifdef CORR_PEAK_EN
    logic [CW-1:0] pval_q, pval_d;
    logic [15:0]   pidx_q, pidx_d;
    logic          pfull_q, pfull_d;

    always_comb begin
        pval_d  = pval_q;
        pidx_d  = pidx_q;
        pfull_d = pfull_q;
        if (peak_clr) begin
            pval_d  = '0;
            pidx_d  = '0;
            pfull_d = 1'b0;
        end else if (hs && (!pfull_q || ($signed(corr) > $signed(pval_q)))) begin
            pval_d  = corr;
            pidx_d  = widx_q;
            pfull_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pval_q  <= '0;
            pidx_q  <= '0;
            pfull_q <= 1'b0;
        end else begin
            pval_q  <= pval_d;
            pidx_q  <= pidx_d;
            pfull_q <= pfull_d;
        end
    end

    assign peak_val = pval_q;
    assign peak_idx = pidx_q;
`else
    logic peak_unused;
    assign peak_unused = peak_clr ^ hs;
    assign peak_val    = '0;
    assign peak_idx    = '0;
`endif

endmodule

// File: tb/tb_correlador_ctrl.sv
// Directed self-checking bench for correlador_ctrl at default parameters (N=1024, NS=16, CW=12).
module tb_correlador_ctrl;

    localparam int CW = 12;
    localparam logic [CW-1:0] P1024 = 12'd1024;
    localparam logic [CW-1:0] M1024 = 12'hC00;

    logic          clk = 1'b0;
    logic          rst_n, start, in_valid, out_ready, peak_clr;
    logic          in_ready, out_valid, busy;
    logic [63:0]   in_a, in_b;
    logic [CW-1:0] corr, peak_val;
    logic [15:0]   peak_idx;

    int n_cmp = 0;
    int n_err = 0;

    correlador_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .out_valid(out_valid),
        .out_ready(out_ready), .corr(corr), .busy(busy), .peak_clr(peak_clr),
        .peak_val(peak_val), .peak_idx(peak_idx)
    );

    always #5 clk = ~clk;

    task automatic do_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    // One accepted beat; gap idle cycles first. Entered and left at a negedge.
    task automatic send_beat(input logic [63:0] a, input logic [63:0] b, input int gap);
        for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            @(negedge clk);
            n_cmp++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL stall_hold: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
            end
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL beat_ready: in_ready=%b want 1", in_ready);
        end
        in_valid = 1'b1; in_a = a; in_b = b;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    // Full window with a given total of mismatching bits; corr = 1024 - 2*mism.
    task automatic run_window(input int mism);
        int rem, k;
        logic [63:0] a, mask;
        rem = mism;
        a = 64'hA5C3_0F96_5A3C_F069;
        do_start();
        for (int i = 0; i < 16; i++) begin
            k = (rem > 64) ? 64 : rem;
            rem -= k;
            mask = (k >= 64) ? '1 : ((64'd1 << k) - 64'd1);
            send_beat(a, a ^ mask, 0);
            a = {a[62:0], a[63]};
        end
    endtask

    task automatic check_idle_zero(input string tag);
        n_cmp++;
        if ({in_ready, out_valid, busy} !== 3'b000 || corr !== '0 ||
            peak_val !== '0 || peak_idx !== 16'd0) begin
            n_err++;
            $display("FAIL %s: rdy=%b vld=%b busy=%b corr=%0h pv=%0h pi=%0h want all 0",
                     tag, in_ready, out_valid, busy, corr, peak_val, peak_idx);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; peak_clr = 1'b0;
        in_a = '0; in_b = '0;
        #1;
        check_idle_zero("reset_state");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_zero("after_release");
    endtask

    task automatic test_all_equal();
        do_start();
        for (int i = 0; i < 15; i++) send_beat('0, '0, 0);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL early_valid: out_valid=%b want 0 after 15 beats", out_valid);
        end
        send_beat('0, '0, 0);
        n_cmp++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1 || corr !== P1024) begin
            n_err++;
            $display("FAIL equal_corr: vld=%b rdy=%b busy=%b corr=%0h want 1/0/1/400",
                     out_valid, in_ready, busy, corr);
        end
        handshake();
        n_cmp++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || corr !== '0) begin
            n_err++;
            $display("FAIL post_hs: vld=%b busy=%b corr=%0h want 0/0/0", out_valid, busy, corr);
        end
    endtask

    task automatic test_inverted();
        logic [63:0] a;
        a = 64'h1234_5678_9ABC_DEF0;
        do_start();
        for (int i = 0; i < 16; i++) begin
            send_beat(a, ~a, 0);
            a = a + 64'h0F0F_0F0F_0F0F_0F0F;
        end
        n_cmp++;
        if (out_valid !== 1'b1 || corr !== M1024) begin
            n_err++;
            $display("FAIL inverted_corr: vld=%b corr=%0h want 1/c00", out_valid, corr);
        end
        handshake();
    endtask

    task automatic test_stall();
        do_start();
        for (int i = 0; i < 16; i++) begin
            if (i < 8) send_beat(64'hDEAD_BEEF_0000_FFFF, 64'hDEAD_BEEF_0000_FFFF, 3);
            else       send_beat(64'hDEAD_BEEF_0000_FFFF, 64'h2152_4110_FFFF_0000, 3);
            n_cmp++;
            if (out_valid !== (i == 15)) begin
                n_err++;
                $display("FAIL stall_count: beat %0d out_valid=%b want %b", i, out_valid, i == 15);
            end
        end
        n_cmp++;
        if (corr !== '0) begin
            n_err++;
            $display("FAIL stall_corr: corr=%0h want 0", corr);
        end
        handshake();
    endtask

    task automatic test_hold();
        run_window(0);
        start = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b1 || corr !== P1024 || in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL hold: cyc %0d vld=%b corr=%0h rdy=%b want 1/400/0",
                         c, out_valid, corr, in_ready);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0; start = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL start_with_hs: busy=%b vld=%b want 0/0", busy, out_valid);
        end
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL no_new_window: busy=%b rdy=%b want 0/0", busy, in_ready);
        end
    endtask

    task automatic test_mid_reset();
        do_start();
        for (int i = 0; i < 7; i++) send_beat('1, '1, 0);
        #2 rst_n = 1'b0;
        #1;
        check_idle_zero("mid_reset");
        @(negedge clk) rst_n = 1'b1;
        run_window(0);
        n_cmp++;
        if (out_valid !== 1'b1 || corr !== P1024) begin
            n_err++;
            $display("FAIL post_reset_window: vld=%b corr=%0h want 1/400", out_valid, corr);
        end
        handshake();
    endtask

    task automatic test_peak();
        logic [CW-1:0] exp_corr [3];
        int mism [3];
        exp_corr[0] = 12'd100; exp_corr[1] = 12'd300; exp_corr[2] = 12'd200;
        mism[0] = 462; mism[1] = 362; mism[2] = 412;
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        for (int w = 0; w < 3; w++) begin
            run_window(mism[w]);
            n_cmp++;
            if (corr !== exp_corr[w]) begin
                n_err++;
                $display("FAIL peak_win_corr: win %0d corr=%0d want %0d", w, corr, exp_corr[w]);
            end
            handshake();
`ifdef CORR_PEAK_EN
            if (w == 0) begin
                n_cmp++;
                if (peak_val !== 12'd100 || peak_idx !== 16'd0) begin
                    n_err++;
                    $display("FAIL peak_first: pv=%0d pi=%0d want 100/0", peak_val, peak_idx);
                end
            end
`endif
        end
`ifdef CORR_PEAK_EN
        n_cmp++;
        if (peak_val !== 12'd300 || peak_idx !== 16'd1) begin
            n_err++;
            $display("FAIL peak_track: pv=%0d pi=%0d want 300/1", peak_val, peak_idx);
        end
`else
        n_cmp++;
        if (peak_val !== '0 || peak_idx !== 16'd0) begin
            n_err++;
            $display("FAIL peak_tied: pv=%0d pi=%0d want 0/0", peak_val, peak_idx);
        end
`endif
        peak_clr = 1'b1;
        @(negedge clk) peak_clr = 1'b0;
        n_cmp++;
        if (peak_val !== '0 || peak_idx !== 16'd0) begin
            n_err++;
            $display("FAIL peak_clear: pv=%0d pi=%0d want 0/0", peak_val, peak_idx);
        end
    endtask

    initial begin
        test_reset();
        test_all_equal();
        test_inverted();
        test_stall();
        test_hold();
        test_mid_reset();
        test_peak();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
